// File: rtl/instr_exec_sequencer_if.sv
// Host/instruction-register bus of the execute sequencer: run control, status,
// instruction read port and result write port.
interface instr_exec_sequencer_if;
    logic        start;
    logic        abort;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  rd_ptr;
    logic [67:0] rd_instr;     // {opcode[3:0], op_a[31:0], op_b[31:0]}
    logic        wr_en;
    logic [4:0]  wr_ptr;
    logic [31:0] wr_res;
    logic        busy;
    logic        done;
    logic        err_div0;
    logic        err_opc;
    logic [5:0]  exec_count;

    modport master (
        output start, abort, first_addr, last_addr, rd_instr,
        input  rd_ptr, wr_en, wr_ptr, wr_res, busy, done, err_div0, err_opc, exec_count
    );

    modport slave (
        input  start, abort, first_addr, last_addr, rd_instr,
        output rd_ptr, wr_en, wr_ptr, wr_res, busy, done, err_div0, err_opc, exec_count
    );
endinterface

// File: rtl/instr_exec_sequencer.sv
// Walks a wrap-around range of the 32-entry instruction register, executes each
// opcode on a multi-cycle ALU and writes the result back to the same entry.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; bus outputs hold their last values
// S_READ  | latch rd_instr for rd_ptr, load latency down-counter
// S_EXEC  | ALU busy until the latency counter reaches zero
// S_WRITE | wr_en high, result written to wr_ptr, advance or finish
// S_DONE  | one-cycle done pulse, then back to idle
module instr_exec_sequencer #(
    parameter int unsigned DIV_CYCLES  = 4,
    parameter int unsigned MULT_CYCLES = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    instr_exec_sequencer_if.slave bus
);

    typedef logic        [4:0]  address_t;
    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] operand_d_t;

    typedef struct packed {
        logic [3:0] opc;
        operand_t   op_a;
        operand_t   op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    localparam logic [3:0] MULT_LAT_M1 = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAT_M1  = 4'(DIV_CYCLES - 1);
    localparam operand_t   INT_MIN     = operand_t'(32'h8000_0000);
    localparam operand_t   MINUS_ONE   = operand_t'(32'hFFFF_FFFF);

    state_t       state_q,    state_d;
    address_t     rd_ptr_q,   rd_ptr_d;
    address_t     last_q,     last_d;
    instruction_t instr_q,    instr_d;
    logic [3:0]   cnt_q,      cnt_d;
    address_t     wr_ptr_q,   wr_ptr_d;
    operand_t     wr_res_q,   wr_res_d;
    logic [5:0]   exec_cnt_q, exec_cnt_d;
    logic         err_div0_q, err_div0_d;
    logic         err_opc_q,  err_opc_d;

    instruction_t rd_ins;
    operand_t     alu_res;
    logic         alu_div0;
    logic         alu_opc_bad;

    assign rd_ins = instruction_t'(bus.rd_instr);

    // Counter is loaded with L-1 so the EXEC stage lasts exactly L cycles.
    function automatic logic [3:0] lat_m1(input logic [3:0] opc);
        case (opc)
            OP_MULT:         return MULT_LAT_M1;
            OP_DIV, OP_MOD:  return DIV_LAT_M1;
            default:         return 4'd0;
        endcase
    endfunction

    always_comb begin
        alu_res     = '0;
        alu_div0    = 1'b0;
        alu_opc_bad = 1'b0;
        case (instr_q.opc)
            OP_ZERO:  alu_res = '0;
            OP_PASSA: alu_res = instr_q.op_a;
            OP_PASSB: alu_res = instr_q.op_b;
            OP_ADD:   alu_res = instr_q.op_a + instr_q.op_b;
            OP_SUB:   alu_res = instr_q.op_a - instr_q.op_b;
            OP_MULT:  alu_res = operand_t'(operand_d_t'(instr_q.op_a) * operand_d_t'(instr_q.op_b));
            OP_DIV: begin
                if (instr_q.op_b == '0) begin
                    alu_div0 = 1'b1;
                end else if (instr_q.op_a == INT_MIN && instr_q.op_b == MINUS_ONE) begin
                    alu_res = INT_MIN;  // wraps, as the truncated 32-bit quotient would
                end else begin
                    alu_res = instr_q.op_a / instr_q.op_b;
                end
            end
            OP_MOD: begin
                if (instr_q.op_b == '0) begin
                    alu_div0 = 1'b1;
                end else if (instr_q.op_a == INT_MIN && instr_q.op_b == MINUS_ONE) begin
                    alu_res = '0;
                end else begin
                    alu_res = instr_q.op_a % instr_q.op_b;
                end
            end
            default:  alu_opc_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        last_d     = last_q;
        instr_d    = instr_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        wr_res_d   = wr_res_q;
        exec_cnt_d = exec_cnt_q;
        err_div0_d = err_div0_q;
        err_opc_d  = err_opc_q;

        if (state_q != S_IDLE && bus.abort) begin
            // The write strobe of an aborted WRITE cycle still goes out, so count it.
            state_d = S_IDLE;
            if (state_q == S_WRITE) begin
                exec_cnt_d = exec_cnt_q + 6'd1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d    = S_READ;
                        rd_ptr_d   = bus.first_addr;
                        last_d     = bus.last_addr;
                        exec_cnt_d = '0;
                        err_div0_d = 1'b0;
                        err_opc_d  = 1'b0;
                    end
                end
                S_READ: begin
                    instr_d = rd_ins;
                    cnt_d   = lat_m1(rd_ins.opc);
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        state_d    = S_WRITE;
                        wr_ptr_d   = rd_ptr_q;
                        wr_res_d   = alu_res;
                        err_div0_d = err_div0_q | alu_div0;
                        err_opc_d  = err_opc_q | alu_opc_bad;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_WRITE: begin
                    exec_cnt_d = exec_cnt_q + 6'd1;
                    if (rd_ptr_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 5'd1;
                        state_d  = S_READ;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            last_q     <= '0;
            instr_q    <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            wr_res_q   <= '0;
            exec_cnt_q <= '0;
            err_div0_q <= 1'b0;
            err_opc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            last_q     <= last_d;
            instr_q    <= instr_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_res_q   <= wr_res_d;
            exec_cnt_q <= exec_cnt_d;
            err_div0_q <= err_div0_d;
            err_opc_q  <= err_opc_d;
        end
    end

    assign bus.rd_ptr     = rd_ptr_q;
    assign bus.wr_en      = (state_q == S_WRITE);
    assign bus.wr_ptr     = wr_ptr_q;
    assign bus.wr_res     = wr_res_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err_div0   = err_div0_q;
    assign bus.err_opc    = err_opc_q;
    assign bus.exec_count = exec_cnt_q;

endmodule
